hist_eq_map: RTL and testbench
==============================

Name: hist_eq_map

Overview:
- Consumes the per-level cumulative count stream from the histogram statistics stage (levels 0..255 in order, emitted during vertical blanking after each frame).
- Converts each count to an equalized gray value and writes it into an internal ping-pong 256x8 LUT.
- Maps the live gray pixel stream through the active LUT.
- Downstream output is a remapped gray stream with delayed sync signals.

Parameters:
- IMG_WIDTH, 640, active pixels per line
- IMG_HEIGHT, 480, active lines per frame
- FRAC_BITS, 16, fixed-point fraction bits of the scale factor

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- pixel_level  in  8  gray level of the current cumulative entry
- pixel_level_acc_num  in  20  cumulative pixel count for levels 0..pixel_level
- pixel_level_valid  in  1  entry qualifier, one entry per cycle
- img_vsync  in  1  frame sync of the pixel stream, high during the frame
- img_href  in  1  pixel valid
- img_gray  in  8  input gray pixel
- post_img_vsync  out  1  img_vsync delayed 2 cycles
- post_img_href  out  1  img_href delayed 2 cycles
- post_img_gray  out  8  mapped pixel
- lut_active  out  1  high once the first complete LUT is in use
- lut_err  out  1  sticky; a load sequence broke

Behaviour:
- Reset: all outputs 0, FSM in WAIT, no pending swap, active bank 0.
- Scale factor: N = IMG_WIDTH*IMG_HEIGHT.
  - Localparam K = (255*2^FRAC_BITS + N/2) / N, 16 bits.
  - Legal only for N >= 256.
- Load pipeline, 2 stages:
  - S1 registers prod = pixel_level_acc_num*K (36 bits), together with level and valid.
  - S2 computes eq = (prod + 2^(FRAC_BITS-1)) >> FRAC_BITS, saturating to 255 if greater.
  - S2 writes eq at address level into the inactive bank.
- Load FSM, tracked on S2 writes:
  - WAIT: a write with level 0 goes to LOAD with expected = 1. A write with any other level is dropped and sets lut_err.
  - LOAD: a write with level == expected increments expected. Level 255 goes to DONE.
  - LOAD: a write with level != expected sets lut_err and returns to WAIT. A new level-0 write restarts LOAD.
  - LOAD: a gap in valid is allowed; the FSM holds.
  - DONE: sets swap_pending and returns to WAIT the next cycle.
- Swap:
  - Rising edge of img_vsync (registered compare) with swap_pending already set in a previous cycle:
    - active bank toggles, swap_pending clears, lut_active sets and stays set until reset.
  - Pending set in the same cycle as the vsync rise: the swap waits for the next frame start.
  - A load still in progress at the vsync rise does not swap. It continues into the inactive bank and swaps at the following frame.
  - A new complete load while swap_pending is set overwrites the inactive bank; pending stays set.
- Pixel path:
  - Cycle t: img_gray is registered along with sync.
  - Cycle t+1: synchronous LUT read from the active bank.
  - Cycle t+2: post_img_gray is valid.
  - post_img_vsync and post_img_href are delayed exactly 2 cycles.
  - When lut_active = 0, post_img_gray = img_gray delayed 2 cycles (pass-through).
  - When post_img_href = 0, post_img_gray = 0.
- Bank select for pixel reads changes only at the vsync rise, so a frame is never mapped by two LUTs.
- LUT read and write are always on different banks, so there are no read/write collisions.
- Reset mid-load or mid-frame:
  - FSM returns to WAIT, pending and lut_active clear, and outputs go to 0 next cycle.
  - LUT contents are not cleared.

Test Plan:
- IMG 64x64 (N=4096, K=4080). Feed levels 0..255 with acc = 16*(level+1), then raise vsync. The next frame's pixel 15 maps to (256*4080+32768)>>16 = 16, and pixel 255 (acc 4096) maps to 255.
- Before any load, frame of ramp 0..63 with href -> post_img_gray equals the input, 2 cycles later, lut_active = 0.
- Level sequence 0..99, then level 150 -> lut_err = 1, no swap at the next vsync rise, output stays pass-through.
- Complete load where the level-255 write coincides with the vsync rise -> no swap that frame; swap at the next vsync rise; pixels of the current frame use the old mapping.
- Two consecutive loads with different values (all acc = 4096 vs acc = 1) before the vsync rise -> the second wins. All pixels map to 255 for the first set and 0 for the second, whichever loaded last.
- rst asserted mid-frame after lut_active -> next cycle all outputs 0 and lut_active = 0; the following frame is pass-through until a new complete load and swap.

Source files
------------

// File: rtl/hist_eq_map_if.sv
// rtl/hist_eq_map_if.sv - level stream, pixel stream and status bundle for hist_eq_map
interface hist_eq_map_if;
  logic [7:0]  pixel_level;
  logic [19:0] pixel_level_acc_num;
  logic        pixel_level_valid;
  logic        img_vsync;
  logic        img_href;
  logic [7:0]  img_gray;
  logic        post_img_vsync;
  logic        post_img_href;
  logic [7:0]  post_img_gray;
  logic        lut_active;
  logic        lut_err;

  modport master (
    output pixel_level, pixel_level_acc_num, pixel_level_valid,
    output img_vsync, img_href, img_gray,
    input  post_img_vsync, post_img_href, post_img_gray, lut_active, lut_err
  );

  modport slave (
    input  pixel_level, pixel_level_acc_num, pixel_level_valid,
    input  img_vsync, img_href, img_gray,
    output post_img_vsync, post_img_href, post_img_gray, lut_active, lut_err
  );
endinterface

// File: rtl/hist_eq_map.sv
// rtl/hist_eq_map.sv - histogram equalization LUT builder with ping-pong banks and pixel remap
module hist_eq_map #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FRAC_BITS  = 16
) (
  input logic           clk,
  input logic           rst,
  hist_eq_map_if.slave  bus
);
  localparam logic [63:0] N   = 64'(IMG_WIDTH) * 64'(IMG_HEIGHT);
  localparam logic [63:0] K_W = ((64'd255 << FRAC_BITS) + N / 64'd2) / N;
  localparam logic [15:0] K   = K_W[15:0];

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [35:0] s1_prod;
  logic [7:0]  s1_level;
  logic        s1_valid;
  logic [36:0] s2_round, s2_shift;
  logic [7:0]  s2_eq;

  logic [1:0] state;
  logic [7:0] expected;
  logic       swap_pending, bank, lut_active_r, lut_err_r;
  logic       start, step, brk, stray, we, vs_rise, swap;

  logic       vs_p1, hr_p1, vs_p2, hr_p2, act_p2;
  logic [7:0] gray_p1, gray_p2, rd_data;
  logic [7:0] lut [0:511];

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= bus.pixel_level_valid;
    s1_prod  <= 36'(bus.pixel_level_acc_num) * 36'(K);
    s1_level <= bus.pixel_level;
  end

  always_comb begin
    s2_round = {1'b0, s1_prod} + (37'd1 << (FRAC_BITS - 1));
    s2_shift = s2_round >> FRAC_BITS;
    s2_eq    = (s2_shift > 37'd255) ? 8'hff : s2_shift[7:0];
  end

  // Only writes the FSM accepts reach the inactive bank, so a stray entry
  // cannot corrupt a LUT that is already waiting to be swapped in.
  always_comb begin
    start   = s1_valid && (state != ST_LOAD) && (s1_level == 8'd0);
    stray   = s1_valid && (state != ST_LOAD) && (s1_level != 8'd0);
    step    = s1_valid && (state == ST_LOAD) && (s1_level == expected);
    brk     = s1_valid && (state == ST_LOAD) && (s1_level != expected);
    we      = start || step;
    vs_rise = bus.img_vsync && !vs_p1;
    swap    = vs_rise && swap_pending && (state != ST_LOAD) && !we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WAIT;
      expected     <= 8'd0;
      swap_pending <= 1'b0;
      bank         <= 1'b0;
      lut_active_r <= 1'b0;
      lut_err_r    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (step) begin
            expected <= expected + 8'd1;
            if (s1_level == 8'hff) state <= ST_DONE;
          end else if (brk) begin
            state <= ST_WAIT;
          end
        end
        default: begin
          if (start) begin
            state    <= ST_LOAD;
            expected <= 8'd1;
          end else begin
            state <= ST_WAIT;
          end
        end
      endcase
      if (stray || brk) lut_err_r <= 1'b1;
      // A broken load has partially overwritten the inactive bank.
      if (state == ST_DONE) swap_pending <= 1'b1;
      if (swap || brk)      swap_pending <= 1'b0;
      if (swap) begin
        bank         <= ~bank;
        lut_active_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) lut[{~bank, s1_level}] <= s2_eq;
    rd_data <= lut[{bank, gray_p1}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_p1   <= 1'b0;
      hr_p1   <= 1'b0;
      gray_p1 <= 8'd0;
      vs_p2   <= 1'b0;
      hr_p2   <= 1'b0;
      gray_p2 <= 8'd0;
      act_p2  <= 1'b0;
    end else begin
      vs_p1   <= bus.img_vsync;
      hr_p1   <= bus.img_href;
      gray_p1 <= bus.img_gray;
      vs_p2   <= vs_p1;
      hr_p2   <= hr_p1;
      gray_p2 <= gray_p1;
      act_p2  <= lut_active_r;
    end
  end

  assign bus.post_img_vsync = vs_p2;
  assign bus.post_img_href  = hr_p2;
  assign bus.post_img_gray  = hr_p2 ? (act_p2 ? rd_data : gray_p2) : 8'd0;
  assign bus.lut_active     = lut_active_r;
  assign bus.lut_err        = lut_err_r;
endmodule

// File: tb/tb_hist_eq_map.sv
// tb/tb_hist_eq_map.sv - self-checking bench for hist_eq_map
module tb_hist_eq_map;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int N  = W * H;
  localparam int FB = 16;
  localparam int K  = ((255 << FB) + N / 2) / N;

  typedef struct { logic vs; logic hr; logic [7:0] g; bit tab; } pix_t;
  typedef struct { logic [7:0] g; logic [7:0] exp; } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hist_eq_map_if bus ();
  hist_eq_map #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int   n_pass = 0, n_chk = 0;
  int   m_cur [256];
  int   m_next[256];
  int   acc_buf[256];
  bit   m_act, m_pend, m_prev_vs;
  logic cur_vs;
  bit   ovr_en;
  logic [7:0] ovr_g;
  pix_t q[$];
  vec_t tab[6];

  function automatic int eqv(input int acc);
    longint p;
    p = (longint'(acc) * K + (longint'(1) << (FB - 1))) >>> FB;
    return (p > 255) ? 255 : int'(p);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic [7:0] g,
                     input logic lv, input logic [7:0] lvl, input logic [19:0] acc);
    pix_t e;
    @(posedge clk); #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk(e.tab ? "tab_pix" : "pix",
          {bus.post_img_vsync, bus.post_img_href, bus.post_img_gray}, {e.vs, e.hr, e.g});
    end
    if (vs && !m_prev_vs && m_pend) begin
      m_cur  = m_next;
      m_act  = 1'b1;
      m_pend = 1'b0;
    end
    m_prev_vs = vs;
    e.vs  = vs;
    e.hr  = hr;
    e.tab = ovr_en;
    if (ovr_en) e.g = ovr_g;
    else        e.g = hr ? (m_act ? 8'(m_cur[g]) : g) : 8'd0;
    q.push_back(e);
    bus.img_vsync = vs;  bus.img_href = hr;  bus.img_gray = g;
    bus.pixel_level_valid = lv;  bus.pixel_level = lvl;  bus.pixel_level_acc_num = acc;
    cur_vs = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(cur_vs, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
  endtask

  task automatic load(input bit gaps);
    for (int l = 0; l < 256; l++) begin
      if (gaps && $urandom_range(0, 7) == 0) idle(1);
      cyc(cur_vs, 1'b0, 8'd0, 1'b1, 8'(l), 20'(acc_buf[l]));
    end
    idle(2);
    for (int l = 0; l < 256; l++) m_next[l] = eqv(acc_buf[l]);
    m_pend = 1'b1;
  endtask

  task automatic frame(input int mode, input int nl, input int np);
    logic [7:0] g;
    logic hr;
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    for (int ln = 0; ln < nl; ln++) begin
      for (int px = 0; px < np; px++) begin
        if (mode == 1) begin g = 8'(px); hr = 1'b1; end
        else begin g = 8'($urandom_range(0, 255)); hr = ($urandom_range(0, 4) != 0); end
        cyc(1'b1, hr, g, 1'b0, 8'd0, 20'd0);
      end
      cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    idle(2);
    chk("lut_active", 32'(bus.lut_active), 32'(m_act));
  endtask

  task automatic do_reset();
    pix_t e;
    rst = 1'b1;
    bus.pixel_level_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_outputs", {bus.post_img_vsync, bus.post_img_href, bus.post_img_gray,
                        bus.lut_active, bus.lut_err}, 32'd0);
    rst = 1'b0;
    bus.img_vsync = 1'b0;  bus.img_href = 1'b0;  bus.img_gray = 8'd0;
    bus.pixel_level = 8'd0;  bus.pixel_level_acc_num = 20'd0;
    q.delete();
    e.vs = 1'b0;  e.hr = 1'b0;  e.g = 8'd0;  e.tab = 1'b0;
    q.push_back(e);
    m_act = 1'b0;  m_pend = 1'b0;  m_prev_vs = 1'b0;  cur_vs = 1'b0;
  endtask

  task automatic rand_acc();
    int a;
    a = 0;
    for (int l = 0; l < 256; l++) begin
      a += $urandom_range(0, 40);
      acc_buf[l] = a;
    end
  endtask

  initial begin
    tab[0] = '{8'd0,   8'd1};
    tab[1] = '{8'd15,  8'd16};
    tab[2] = '{8'd63,  8'd64};
    tab[3] = '{8'd127, 8'd128};
    tab[4] = '{8'd200, 8'd200};
    tab[5] = '{8'd255, 8'd255};
    ovr_en = 1'b0;  ovr_g = 8'd0;
    rst = 1'b1;
    bus.img_vsync = 1'b0;  bus.img_href = 1'b0;  bus.img_gray = 8'd0;
    bus.pixel_level_valid = 1'b0;  bus.pixel_level = 8'd0;  bus.pixel_level_acc_num = 20'd0;
    repeat (2) @(posedge clk);
    do_reset();

    // Pass-through before any LUT exists.
    frame(1, 1, 64);

    // Broken sequence 0..99 then 150.
    for (int l = 0; l < 100; l++) cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'(l), 20'(16 * (l + 1)));
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd150, 20'd2416);
    idle(4);
    chk("lut_err_set", 32'(bus.lut_err), 32'd1);
    frame(0, 2, 20);

    // Linear load: acc = 16*(level+1).
    for (int l = 0; l < 256; l++) acc_buf[l] = 16 * (l + 1);
    load(1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    for (int i = 0; i < 6; i++) begin
      ovr_en = 1'b1;  ovr_g = tab[i].exp;
      cyc(1'b1, 1'b1, tab[i].g, 1'b0, 8'd0, 20'd0);
      ovr_en = 1'b0;
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    idle(2);
    chk("lut_active_set", 32'(bus.lut_active), 32'd1);
    frame(0, 3, 24);

    // Level-255 write lands on the vsync rise: no swap this frame.
    rand_acc();
    for (int l = 0; l < 255; l++) cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'(l), 20'(acc_buf[l]));
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 8'd255, 20'(acc_buf[255]));
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    for (int l = 0; l < 256; l++) m_next[l] = eqv(acc_buf[l]);
    m_pend = 1'b1;
    for (int i = 0; i < 40; i++)
      cyc(1'b1, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 1'b0, 8'd0, 20'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    idle(2);
    frame(0, 3, 24);

    // Two complete loads before one frame start: the last one wins.
    for (int l = 0; l < 256; l++) acc_buf[l] = 4096;
    load(1'b1);
    for (int l = 0; l < 256; l++) acc_buf[l] = 1;
    load(1'b1);
    frame(0, 2, 24);
    load(1'b0);
    for (int l = 0; l < 256; l++) acc_buf[l] = 4096;
    load(1'b1);
    frame(0, 2, 24);

    for (int r = 0; r < 3; r++) begin
      rand_acc();
      load(1'b1);
      frame(0, 3, 24);
    end

    // Reset in the middle of a mapped frame.
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 20'd0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'd0, 20'd0);
    do_reset();
    frame(0, 2, 24);
    rand_acc();
    load(1'b1);
    frame(0, 3, 24);
    idle(3);
    chk("lut_err_after_reset", 32'(bus.lut_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
